cpu6502_bus_ctrl: RTL and testbench

//  Memory/IO bus controller directly downstream of the 6502 core: consumes the core's address, R/W and

---
 rtl/cpu6502_pkg.sv | 21 ++
 rtl/cpu6502_bus_ctrl_if.sv | 37 +++
 rtl/cpu6502_addr_decode.sv | 35 +++
 rtl/cpu6502_bus_ctrl.sv | 155 +++++++++++++++
 tb/tb_cpu6502_bus_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu6502_pkg.sv
// rtl/cpu6502_pkg.sv - shared types and default memory map for the 6502 bus controller
package cpu6502_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_IO_REQ
  } bus_state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_IO,
    RGN_ROM,
    RGN_NONE
  } region_e;

  localparam logic [15:0] DEF_RAM_TOP  = 16'h7FFF;
  localparam logic [15:0] DEF_IO_BASE  = 16'h8000;
  localparam logic [15:0] DEF_ROM_BASE = 16'hC000;

endpackage

// File: rtl/cpu6502_bus_ctrl_if.sv
// rtl/cpu6502_bus_ctrl_if.sv - core, memory and IO bus signals around the bus controller
interface cpu6502_bus_ctrl_if;

  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [7:0]  rom_rdata;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic        bus_err;

  modport master (
    input  cpu_addr, cpu_rw, cpu_dout, ram_rdata, rom_rdata, io_rdata, io_ack,
    output cpu_din, cpu_rdy, ram_en, ram_we, ram_addr, ram_wdata,
    output rom_en, rom_addr, io_req, io_we, io_addr, io_wdata, bus_err
  );

  modport slave (
    output cpu_addr, cpu_rw, cpu_dout, ram_rdata, rom_rdata, io_rdata, io_ack,
    input  cpu_din, cpu_rdy, ram_en, ram_we, ram_addr, ram_wdata,
    input  rom_en, rom_addr, io_req, io_we, io_addr, io_wdata, bus_err
  );

endinterface

// File: rtl/cpu6502_addr_decode.sv
// rtl/cpu6502_addr_decode.sv - combinational region decode and region-local addresses
module cpu6502_addr_decode
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] RAM_TOP  = DEF_RAM_TOP,
  parameter logic [15:0] IO_BASE  = DEF_IO_BASE,
  parameter logic [15:0] ROM_BASE = DEF_ROM_BASE
) (
  input  logic [15:0] addr_i,
  output region_e     region_o,
  output logic [14:0] ram_addr_o,
  output logic [13:0] rom_addr_o,
  output logic [7:0]  io_addr_o
);

  localparam logic [16:0] IO_LAST = {1'b0, IO_BASE} + 17'd255;

  // Priority order also settles overlapping regions when the map is misconfigured.
  always_comb begin
    region_o = RGN_NONE;
    if (addr_i <= RAM_TOP) begin
      region_o = RGN_RAM;
    end else if (addr_i >= IO_BASE && {1'b0, addr_i} <= IO_LAST) begin
      region_o = RGN_IO;
    end else if (addr_i >= ROM_BASE) begin
      region_o = RGN_ROM;
    end
  end

  // Offsets wrap modulo the region width, so only the low bits need subtracting.
  assign ram_addr_o = addr_i[14:0];
  assign rom_addr_o = addr_i[13:0] - ROM_BASE[13:0];
  assign io_addr_o  = addr_i[7:0] - IO_BASE[7:0];

endmodule

// File: rtl/cpu6502_bus_ctrl.sv
// rtl/cpu6502_bus_ctrl.sv - 6502 bus controller: region decode, wait states, IO handshake, read return
module cpu6502_bus_ctrl
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] RAM_TOP    = DEF_RAM_TOP,
  parameter logic [15:0] IO_BASE    = DEF_IO_BASE,
  parameter logic [15:0] ROM_BASE   = DEF_ROM_BASE,
  parameter int unsigned RAM_WS     = 0,
  parameter int unsigned ROM_WS     = 1,
  parameter int unsigned IO_TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               res_i,
  cpu6502_bus_ctrl_if.master bus
);

  localparam logic [3:0] RAM_WS4     = 4'(RAM_WS);
  localparam logic [3:0] ROM_WS4     = 4'(ROM_WS);
  localparam logic [7:0] IO_LAST_CNT = 8'(IO_TIMEOUT - 1);

  region_e     rgn;
  logic [14:0] ram_a;
  logic [13:0] rom_a;
  logic [7:0]  io_a;

  cpu6502_addr_decode #(
    .RAM_TOP (RAM_TOP),
    .IO_BASE (IO_BASE),
    .ROM_BASE(ROM_BASE)
  ) u_decode (
    .addr_i    (bus.cpu_addr),
    .region_o  (rgn),
    .ram_addr_o(ram_a),
    .rom_addr_o(rom_a),
    .io_addr_o (io_a)
  );

  bus_state_e state_q;
  region_e    rgn_q;
  logic       rdy_q, err_q, req_q, io_we_q, rw_q, mem_vld_q, mem_rom_q;
  logic [7:0] din_q, io_addr_q, io_wdata_q, io_cnt_q;
  logic [3:0] ws_q;

  logic       accept, reissue;
  logic [3:0] mem_ws;
  logic [7:0] din_now;

  assign accept  = rdy_q && (state_q == ST_IDLE);
  assign reissue = (state_q == ST_WAIT) && (ws_q == 4'd0) && rw_q;
  assign mem_ws  = (rgn == RGN_RAM) ? RAM_WS4 : ROM_WS4;

  // Sync memories present their data the cycle after enable; hand it straight through then.
  assign din_now = mem_vld_q ? (mem_rom_q ? bus.rom_rdata : bus.ram_rdata) : din_q;

  assign bus.ram_en    = (accept && rgn == RGN_RAM) || (reissue && rgn_q == RGN_RAM);
  assign bus.ram_we    = accept && rgn == RGN_RAM && !bus.cpu_rw;
  assign bus.ram_addr  = ram_a;
  assign bus.ram_wdata = bus.cpu_dout;
  assign bus.rom_en    = (accept && rgn == RGN_ROM && bus.cpu_rw) || (reissue && rgn_q == RGN_ROM);
  assign bus.rom_addr  = rom_a;
  assign bus.cpu_din   = din_now;
  assign bus.cpu_rdy   = rdy_q;
  assign bus.io_req    = req_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;
  assign bus.bus_err   = err_q;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q    <= ST_IDLE;
      rgn_q      <= RGN_NONE;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      io_we_q    <= 1'b0;
      rw_q       <= 1'b1;
      mem_vld_q  <= 1'b0;
      mem_rom_q  <= 1'b0;
      din_q      <= 8'hFF;
      io_addr_q  <= 8'h00;
      io_wdata_q <= 8'h00;
      io_cnt_q   <= 8'h00;
      ws_q       <= 4'd0;
    end else begin
      err_q     <= 1'b0;
      mem_vld_q <= 1'b0;
      din_q     <= din_now;
      case (state_q)
        ST_IDLE: begin
          if (!rdy_q) begin
            rdy_q <= 1'b1;
          end else begin
            case (rgn)
              RGN_RAM, RGN_ROM: begin
                rgn_q <= rgn;
                rw_q  <= bus.cpu_rw;
                if (mem_ws == 4'd0) begin
                  mem_vld_q <= bus.cpu_rw;
                  mem_rom_q <= (rgn == RGN_ROM);
                end else begin
                  state_q <= ST_WAIT;
                  ws_q    <= mem_ws - 4'd1;
                  rdy_q   <= 1'b0;
                end
              end
              RGN_IO: begin
                state_q    <= ST_IO_REQ;
                req_q      <= 1'b1;
                rdy_q      <= 1'b0;
                rw_q       <= bus.cpu_rw;
                io_we_q    <= !bus.cpu_rw;
                io_addr_q  <= io_a;
                io_wdata_q <= bus.cpu_dout;
                io_cnt_q   <= 8'h00;
              end
              default: begin
                err_q <= 1'b1;
                if (bus.cpu_rw) din_q <= 8'hFF;
              end
            endcase
          end
        end
        ST_WAIT: begin
          if (ws_q == 4'd0) begin
            state_q   <= ST_IDLE;
            rdy_q     <= 1'b1;
            mem_vld_q <= rw_q;
            mem_rom_q <= (rgn_q == RGN_ROM);
          end else begin
            ws_q <= ws_q - 4'd1;
          end
        end
        ST_IO_REQ: begin
          if (bus.io_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            rdy_q   <= 1'b1;
            if (rw_q) din_q <= bus.io_rdata;
          end else if (io_cnt_q == IO_LAST_CNT) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b1;
            if (rw_q) din_q <= 8'hFF;
          end else begin
            io_cnt_q <= io_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6502_bus_ctrl.sv
// tb/tb_cpu6502_bus_ctrl.sv - directed self-checking bench for cpu6502_bus_ctrl
module tb_cpu6502_bus_ctrl;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu6502_bus_ctrl_if bus ();

  cpu6502_bus_ctrl dut (
    .clk_i(clk),
    .res_i(res),
    .bus  (bus)
  );

  logic [7:0] ram_mem [0:32767] = '{16: 8'h3C, 17: 8'hA7, default: 8'h00};

  // Sync RAM and ROM; ROM content is a fixed function of its local address.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
    if (bus.rom_en) bus.rom_rdata <= bus.rom_addr[7:0] ^ {2'b10, bus.rom_addr[13:8]};
  end

  task automatic park;
    bus.cpu_addr = 16'h0000;
    bus.cpu_rw   = 1'b1;
    bus.cpu_dout = 8'h00;
    bus.io_ack   = 1'b0;
  endtask

  task automatic test_reset;
    park();
    bus.io_rdata = 8'h00;
    res = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %h want 0", bus.cpu_rdy); end
    checks++; if (bus.cpu_din !== 8'hFF) begin errors++; $display("FAIL reset_din: got %h want ff", bus.cpu_din); end
    checks++; if (bus.io_req !== 1'b0) begin errors++; $display("FAIL reset_io_req: got %h want 0", bus.io_req); end
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %h want 0", bus.bus_err); end
    checks++; if (bus.ram_en !== 1'b0 || bus.rom_en !== 1'b0) begin errors++; $display("FAIL reset_en: got ram %h rom %h want 0 0", bus.ram_en, bus.rom_en); end
    res = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy: got %h want 1", bus.cpu_rdy); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bus.cpu_addr = 16'h0010;
    #1;
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 15'h0010) begin errors++; $display("FAIL ram_rd_en: got en %h we %h addr %h want 1 0 0010", bus.ram_en, bus.ram_we, bus.ram_addr); end
    @(negedge clk);
    checks++; if (bus.cpu_din !== 8'h3C) begin errors++; $display("FAIL b2b_din0: got %h want 3c", bus.cpu_din); end
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy0: got %h want 1", bus.cpu_rdy); end
    bus.cpu_addr = 16'h0011;
    @(negedge clk);
    checks++; if (bus.cpu_din !== 8'hA7) begin errors++; $display("FAIL b2b_din1: got %h want a7", bus.cpu_din); end
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy1: got %h want 1", bus.cpu_rdy); end
    park();
    @(negedge clk);
  endtask

  task automatic test_ram_write;
    bus.cpu_addr = 16'h0020; bus.cpu_rw = 1'b0; bus.cpu_dout = 8'h77;
    #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_wdata !== 8'h77) begin errors++; $display("FAIL ram_wr_we: got we %h data %h want 1 77", bus.ram_we, bus.ram_wdata); end
    @(negedge clk);
    checks++; if (bus.cpu_din !== 8'h00) begin errors++; $display("FAIL ram_wr_din_hold: got %h want 00", bus.cpu_din); end
    bus.cpu_rw = 1'b1;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL ram_wr_one_cycle: got %h want 0", bus.ram_we); end
    @(negedge clk);
    checks++; if (bus.cpu_din !== 8'h77) begin errors++; $display("FAIL ram_readback: got %h want 77", bus.cpu_din); end
    park();
    @(negedge clk);
  endtask

  task automatic test_rom_read;
    bus.cpu_addr = 16'hFFFC;
    #1;
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 14'h3FFC) begin errors++; $display("FAIL rom_rd_en: got en %h addr %h want 1 3ffc", bus.rom_en, bus.rom_addr); end
    @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b0) begin errors++; $display("FAIL rom_wait_rdy: got %h want 0", bus.cpu_rdy); end
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL rom_reissue: got %h want 1", bus.rom_en); end
    @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL rom_done_rdy: got %h want 1", bus.cpu_rdy); end
    checks++; if (bus.cpu_din !== 8'h43) begin errors++; $display("FAIL rom_din: got %h want 43", bus.cpu_din); end
    park();
    @(negedge clk);
  endtask

  task automatic test_rom_write;
    bus.cpu_addr = 16'hC000; bus.cpu_rw = 1'b0; bus.cpu_dout = 8'h99;
    #1;
    checks++; if (bus.rom_en !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL rom_wr_en: got rom_en %h ram_we %h want 0 0", bus.rom_en, bus.ram_we); end
    @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b0 || bus.rom_en !== 1'b0) begin errors++; $display("FAIL rom_wr_wait: got rdy %h rom_en %h want 0 0", bus.cpu_rdy, bus.rom_en); end
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL rom_wr_err0: got %h want 0", bus.bus_err); end
    @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b1 || bus.bus_err !== 1'b0) begin errors++; $display("FAIL rom_wr_done: got rdy %h err %h want 1 0", bus.cpu_rdy, bus.bus_err); end
    checks++; if (bus.cpu_din !== 8'h00) begin errors++; $display("FAIL rom_wr_din_hold: got %h want 00", bus.cpu_din); end
    checks++; if (ram_mem[0] !== 8'h00 || ram_mem[15'h4000] !== 8'h00) begin errors++; $display("FAIL rom_wr_ram_intact: got %h %h want 00 00", ram_mem[0], ram_mem[15'h4000]); end
    park();
    @(negedge clk);
  endtask

  task automatic test_io_write;
    int req_cycles = 0;
    bus.cpu_addr = 16'h8005; bus.cpu_rw = 1'b0; bus.cpu_dout = 8'h5A;
    @(negedge clk);
    checks++; if (bus.io_req !== 1'b1 || bus.io_addr !== 8'h05 || bus.io_we !== 1'b1 || bus.io_wdata !== 8'h5A) begin errors++; $display("FAIL io_wr_req: got req %h addr %h we %h data %h want 1 05 1 5a", bus.io_req, bus.io_addr, bus.io_we, bus.io_wdata); end
    checks++; if (bus.cpu_rdy !== 1'b0) begin errors++; $display("FAIL io_wr_stall: got %h want 0", bus.cpu_rdy); end
    for (int i = 0; i < 3; i++) begin
      if (bus.io_req === 1'b1) req_cycles++;
      if (i == 2) bus.io_ack = 1'b1;
      @(negedge clk);
    end
    checks++; if (req_cycles != 3) begin errors++; $display("FAIL io_wr_req_cycles: got %0d want 3", req_cycles); end
    checks++; if (bus.io_req !== 1'b0 || bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL io_wr_done: got req %h rdy %h want 0 1", bus.io_req, bus.cpu_rdy); end
    checks++; if (bus.cpu_din !== 8'h00) begin errors++; $display("FAIL io_wr_din_hold: got %h want 00", bus.cpu_din); end
    park();
    @(negedge clk);
  endtask

  task automatic test_io_read_fast;
    bus.cpu_addr = 16'h8010;
    @(negedge clk);
    checks++; if (bus.io_req !== 1'b1 || bus.io_we !== 1'b0 || bus.io_addr !== 8'h10) begin errors++; $display("FAIL io_rd_req: got req %h we %h addr %h want 1 0 10", bus.io_req, bus.io_we, bus.io_addr); end
    bus.io_ack = 1'b1; bus.io_rdata = 8'hC5;
    @(negedge clk);
    checks++; if (bus.io_req !== 1'b0 || bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL io_rd_done: got req %h rdy %h want 0 1", bus.io_req, bus.cpu_rdy); end
    checks++; if (bus.cpu_din !== 8'hC5) begin errors++; $display("FAIL io_rd_din: got %h want c5", bus.cpu_din); end
    park();
    @(negedge clk);
  endtask

  task automatic test_io_timeout;
    int  n = 0;
    bit  done = 1'b0;
    bus.cpu_addr = 16'h80FF;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.io_req === 1'b1) n++;
      else done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL io_to_bound: io_req still high after 200 cycles, want drop"); end
    checks++; if (n != 64) begin errors++; $display("FAIL io_to_cycles: got %0d want 64", n); end
    checks++; if (bus.bus_err !== 1'b1 || bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL io_to_err: got err %h rdy %h want 1 1", bus.bus_err, bus.cpu_rdy); end
    checks++; if (bus.cpu_din !== 8'hFF || bus.io_addr !== 8'hFF) begin errors++; $display("FAIL io_to_din: got din %h addr %h want ff ff", bus.cpu_din, bus.io_addr); end
    park();
    @(negedge clk);
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL io_to_pulse: got %h want 0", bus.bus_err); end
  endtask

  task automatic test_unmapped;
    bus.cpu_addr = 16'h9000;
    @(negedge clk);
    checks++; if (bus.bus_err !== 1'b1 || bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL unmap_err: got err %h rdy %h want 1 1", bus.bus_err, bus.cpu_rdy); end
    checks++; if (bus.cpu_din !== 8'hFF) begin errors++; $display("FAIL unmap_din: got %h want ff", bus.cpu_din); end
    park();
    @(negedge clk);
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL unmap_pulse: got %h want 0", bus.bus_err); end
  endtask

  task automatic test_reset_mid_io;
    bus.cpu_addr = 16'h8001;
    @(negedge clk);
    checks++; if (bus.io_req !== 1'b1) begin errors++; $display("FAIL rst_io_req: got %h want 1", bus.io_req); end
    res = 1'b1;
    @(negedge clk);
    checks++; if (bus.io_req !== 1'b0 || bus.cpu_rdy !== 1'b0) begin errors++; $display("FAIL rst_io_abort: got req %h rdy %h want 0 0", bus.io_req, bus.cpu_rdy); end
    res = 1'b0;
    park();
    @(negedge clk);
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_io_resume: got %h want 1", bus.cpu_rdy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ram_write();
    test_rom_read();
    test_rom_write();
    test_io_write();
    test_io_read_fast();
    test_io_timeout();
    test_unmapped();
    test_reset_mid_io();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want finish");
    $fatal(1);
  end

endmodule
